// File: rtl/pipe_div_pkg.sv
// Shared defaults for the pipelined-divider flow-control shell.
// Contents: default widths, divider latency, FIFO depth, and the fill bits
// used to build the divide-by-zero result (quotient all ones, remainder zero).
package pipe_div_pkg;

   localparam int unsigned DEND_W_DEF = 16;
   localparam int unsigned SOR_W_DEF  = 10;
   localparam int unsigned LAT_DEF    = 16;
   localparam int unsigned DEPTH_DEF  = 32;

   // Replicated to the parameterised width at the point of use.
   localparam logic DBZ_Q_FILL = 1'b1;
   localparam logic DBZ_R_FILL = 1'b0;

endpackage

// File: rtl/pipe_div_fifo.sv
// Synchronous show-ahead FIFO for divider results.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and payload (ignored when full without a pop)
//   pop               consumer pop (ignored when empty)
//   head_valid        FIFO not empty
//   head_data         head entry, zero when empty
//   count             current occupancy, 0..DEPTH
module pipe_div_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic                         head_valid,
   output logic [W-1:0]                 head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         empty;
   logic         full;
   logic         do_push;
   logic         do_pop;

   // Pointers carry one extra wrap bit, so the difference is the occupancy.
   assign count   = CW'(wr_ptr - rd_ptr);
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so push-at-full is legal then.
   assign do_push = push & (~full | do_pop);

   assign head_valid = ~empty;
   // Masked so stale storage is never presented after a reset.
   assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage; needs no reset because the empty mask hides its contents.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pipe_div_obuf.sv
// Flow-control shell around a non-stallable pipelined unsigned divider.
// Requests are issued straight into the divider under a credit limit that
// reserves an output-FIFO slot for every in-flight operation; results are
// captured into a show-ahead FIFO with a divide-by-zero tag.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_dividend, req_divisor      request operands
//   div_valid_o, div_dividend_o,
//   div_divisor_o                  issue side to the divider
//   div_valid_i, div_quotient_i,
//   div_remainder_i                result side from the divider
//   res_valid/res_ready            result handshake (FIFO head)
//   res_quotient, res_remainder,
//   res_dbz                        result payload
//   ovf_err                        sticky: result arrived with FIFO full
module pipe_div_obuf
   import pipe_div_pkg::*;
#(
   parameter int unsigned DEND_W = DEND_W_DEF,
   parameter int unsigned SOR_W  = SOR_W_DEF,
   parameter int unsigned LAT    = LAT_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DEND_W-1:0] req_dividend,
   input  logic [SOR_W-1:0]  req_divisor,
   output logic              div_valid_o,
   output logic [DEND_W-1:0] div_dividend_o,
   output logic [SOR_W-1:0]  div_divisor_o,
   input  logic              div_valid_i,
   input  logic [DEND_W-1:0] div_quotient_i,
   input  logic [SOR_W-1:0]  div_remainder_i,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DEND_W-1:0] res_quotient,
   output logic [SOR_W-1:0]  res_remainder,
   output logic              res_dbz,
   output logic              ovf_err
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned RW = DEND_W + SOR_W + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LAT < 1)) begin : g_bad_param
      $error("pipe_div_obuf: DEPTH must be a power of two >= 2 and LAT >= 1");
   end

   logic [CW-1:0]     inflight;
   logic [CW-1:0]     count;
   logic [SW-1:0]     credit_used;
   logic              issue;
   logic              issue_dbz;
   logic [LAT-1:0]    dbz_pipe;
   logic              cap_dbz;
   logic [DEND_W-1:0] cap_q;
   logic [SOR_W-1:0]  cap_r;
   logic [RW-1:0]     head_data;
   logic              pop;

   // Credit check uses registered counts only; a pop returns credit next cycle.
   assign credit_used = SW'(inflight) + SW'(count);
   assign req_ready   = ~rst & (credit_used < SW'(DEPTH));
   assign issue       = req_valid & req_ready;

   assign div_valid_o    = issue;
   assign div_dividend_o = req_dividend;
   assign div_divisor_o  = req_divisor;

   assign issue_dbz = issue & (req_divisor == '0);

   // Divide-by-zero tag travels in lockstep with the divider pipeline.
   always_ff @(posedge clk) begin
      if (rst) dbz_pipe <= '0;
      else     dbz_pipe <= LAT'({dbz_pipe, issue_dbz});
   end

   assign cap_dbz = dbz_pipe[LAT-1];
   assign cap_q   = cap_dbz ? {DEND_W{DBZ_Q_FILL}} : div_quotient_i;
   assign cap_r   = cap_dbz ? {SOR_W{DBZ_R_FILL}}  : div_remainder_i;

   // Operations issued but not yet returned by the divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({issue, div_valid_i})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   assign pop = res_valid & res_ready;

   pipe_div_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (div_valid_i),
      .push_data  ({cap_q, cap_r, cap_dbz}),
      .pop        (res_ready),
      .head_valid (res_valid),
      .head_data  (head_data),
      .count      (count)
   );

   assign {res_quotient, res_remainder, res_dbz} = head_data;

   // Sticky overflow flag; the credit scheme should keep this at zero.
   always_ff @(posedge clk) begin
      if (rst) ovf_err <= 1'b0;
      else if (div_valid_i && (count == CW'(DEPTH)) && !pop) ovf_err <= 1'b1;
   end

endmodule

// File: tb/tb_pipe_div_obuf.sv
// Self-checking bench for pipe_div_obuf with a behavioural stand-in for the
// pipelined divider and a queue-based reference model of result order.
module tb_pipe_div_obuf;

   localparam int unsigned LAT   = 16;
   localparam int unsigned DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_dividend;
   logic [9:0]  req_divisor;
   logic        div_valid_o;
   logic [15:0] div_dividend_o;
   logic [9:0]  div_divisor_o;
   logic        div_valid_i;
   logic [15:0] div_quotient_i;
   logic [9:0]  div_remainder_i;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_quotient;
   logic [9:0]  res_remainder;
   logic        res_dbz;
   logic        ovf_err;

   always #5 clk = ~clk;

   pipe_div_obuf dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_dividend    (req_dividend),
      .req_divisor     (req_divisor),
      .div_valid_o     (div_valid_o),
      .div_dividend_o  (div_dividend_o),
      .div_divisor_o   (div_divisor_o),
      .div_valid_i     (div_valid_i),
      .div_quotient_i  (div_quotient_i),
      .div_remainder_i (div_remainder_i),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_quotient    (res_quotient),
      .res_remainder   (res_remainder),
      .res_dbz         (res_dbz),
      .ovf_err         (ovf_err)
   );

   // Stand-in for PIPE_DIV_TOP: LAT-cycle pipeline, reset by rst_n = ~rst,
   // garbage output on divide-by-zero so the override is exercised.
   logic        div_rst_n;
   logic        dv_v [LAT];
   logic [15:0] dv_a [LAT];
   logic [9:0]  dv_b [LAT];

   assign div_rst_n = ~rst;

   always_ff @(posedge clk) begin
      if (!div_rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            dv_v[i] <= 1'b0;
            dv_a[i] <= '0;
            dv_b[i] <= '0;
         end
      end else begin
         dv_v[0] <= div_valid_o;
         dv_a[0] <= div_dividend_o;
         dv_b[0] <= div_divisor_o;
         for (int i = 1; i < LAT; i++) begin
            dv_v[i] <= dv_v[i-1];
            dv_a[i] <= dv_a[i-1];
            dv_b[i] <= dv_b[i-1];
         end
      end
   end

   assign div_valid_i     = dv_v[LAT-1];
   assign div_quotient_i  = (dv_b[LAT-1] == 10'd0) ? 16'h1234 : dv_a[LAT-1] / 16'(dv_b[LAT-1]);
   assign div_remainder_i = (dv_b[LAT-1] == 10'd0) ? 10'h155  : 10'(dv_a[LAT-1] % 16'(dv_b[LAT-1]));

   // Reference model: expected results in acceptance order.
   typedef struct packed {
      logic [15:0] q;
      logic [9:0]  r;
      logic        dbz;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [9:0]  b;
      logic [15:0] q;
      logic [9:0]  r;
      logic        dbz;
   } vec_t;

   res_t exp_q[$];
   vec_t tbl[9];

   int n_vec = 0;
   int n_err = 0;
   int n_pops = 0;
   int max_occ = 0;

   logic        s_req_ready, s_res_valid, s_dbz, s_ovf, s_div_valid_o;
   logic [15:0] s_q;
   logic [9:0]  s_r;

   function automatic res_t golden(input logic [15:0] a, input logic [9:0] b);
      res_t g;
      if (b == 10'd0) begin
         g.q = 16'hFFFF; g.r = 10'd0; g.dbz = 1'b1;
      end else begin
         g.q = a / 16'(b); g.r = 10'(a % 16'(b)); g.dbz = 1'b0;
      end
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: sample at negedge, update the model, return just after posedge.
   task automatic step();
      res_t e;
      @(negedge clk);
      s_req_ready   = req_ready;
      s_res_valid   = res_valid;
      s_q           = res_quotient;
      s_r           = res_remainder;
      s_dbz         = res_dbz;
      s_ovf         = ovf_err;
      s_div_valid_o = div_valid_o;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (res_valid && res_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               chk("unexpected res_valid", 32'(res_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("model quotient", 32'(res_quotient), 32'(e.q));
               chk("model remainder", 32'(res_remainder), 32'(e.r));
               chk("model dbz", 32'(res_dbz), 32'(e.dbz));
            end
         end
         if (req_valid && req_ready) exp_q.push_back(golden(req_dividend, req_divisor));
         if (exp_q.size() > max_occ) max_occ = exp_q.size();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      req_valid = 1'b0;
      res_ready = 1'b1;
      for (int t = 0; t < budget && exp_q.size() != 0; t++) step();
      chk("drain outstanding", 32'(exp_q.size()), 32'd0);
      step();
      chk("idle res_valid", 32'(s_res_valid), 32'd0);
   endtask

   task automatic apply_one(input vec_t v);
      logic acc;
      int   lat;
      acc = 1'b0;
      lat = 0;
      res_ready    = 1'b1;
      req_valid    = 1'b1;
      req_dividend = v.a;
      req_divisor  = v.b;
      for (int t = 0; t < 20 && !acc; t++) begin
         step();
         acc = s_req_ready;
      end
      req_valid = 1'b0;
      chk("single accept", 32'(acc), 32'd1);
      for (int k = 1; k <= 60; k++) begin
         step();
         if (s_res_valid) begin
            lat = k;
            break;
         end
      end
      chk("single latency", 32'(lat), 32'(LAT + 1));
      chk("single quotient", 32'(s_q), 32'(v.q));
      chk("single remainder", 32'(s_r), 32'(v.r));
      chk("single dbz", 32'(s_dbz), 32'(v.dbz));
   endtask

   initial begin
      int  acc;
      int  pops0;
      logic ok;

      tbl[0] = '{16'd100,   10'd7,    16'd14,    10'd2,  1'b0};
      tbl[1] = '{16'd1234,  10'd5,    16'd246,   10'd4,  1'b0};
      tbl[2] = '{16'd1234,  10'd0,    16'hFFFF,  10'd0,  1'b1};
      tbl[3] = '{16'd1234,  10'd5,    16'd246,   10'd4,  1'b0};
      tbl[4] = '{16'd9,     10'd3,    16'd3,     10'd0,  1'b0};
      tbl[5] = '{16'd65535, 10'd1,    16'd65535, 10'd0,  1'b0};
      tbl[6] = '{16'd0,     10'd5,    16'd0,     10'd0,  1'b0};
      tbl[7] = '{16'd65535, 10'd1023, 16'd64,    10'd63, 1'b0};
      tbl[8] = '{16'd5,     10'd1023, 16'd0,     10'd5,  1'b0};

      // Reset behaviour
      rst = 1'b1; req_valid = 1'b1; res_ready = 1'b0;
      req_dividend = 16'd77; req_divisor = 10'd3;
      step();
      step();
      chk("req_ready in reset", 32'(s_req_ready), 32'd0);
      chk("div_valid_o in reset", 32'(s_div_valid_o), 32'd0);
      rst = 1'b0; req_valid = 1'b0;
      step();
      chk("req_ready after reset", 32'(s_req_ready), 32'd1);
      chk("res_valid after reset", 32'(s_res_valid), 32'd0);
      chk("res_quotient after reset", 32'(s_q), 32'd0);
      chk("res_remainder after reset", 32'(s_r), 32'd0);
      chk("res_dbz after reset", 32'(s_dbz), 32'd0);
      chk("ovf_err after reset", 32'(s_ovf), 32'd0);

      // Directed single requests
      for (int i = 0; i < 9; i++) apply_one(tbl[i]);
      drain(50);

      // 64 back-to-back requests
      ok = 1'b1;
      pops0 = n_pops;
      res_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         req_valid    = 1'b1;
         req_dividend = 16'(1 + 3 * i);
         req_divisor  = 10'(1 + 2 * i);
         step();
         if (!s_req_ready) ok = 1'b0;
      end
      chk("b2b req_ready held", 32'(ok), 32'd1);
      drain(200);
      chk("b2b result count", 32'(n_pops - pops0), 32'd64);

      // Fill with consumer stalled: exactly DEPTH accepted
      acc = 0;
      res_ready = 1'b0;
      for (int t = 0; t < 80; t++) begin
         req_valid    = 1'b1;
         req_dividend = 16'($urandom);
         req_divisor  = 10'($urandom);
         step();
         if (s_req_ready) acc++;
      end
      chk("full accepted", 32'(acc), 32'(DEPTH));
      chk("full req_ready", 32'(s_req_ready), 32'd0);
      chk("full ovf_err", 32'(s_ovf), 32'd0);
      pops0 = n_pops;
      drain(200);
      chk("full drain count", 32'(n_pops - pops0), 32'(DEPTH));

      // Full FIFO with results still arriving and consumer toggling
      max_occ = 0;
      for (int t = 0; t < 300; t++) begin
         req_valid    = 1'b1;
         req_dividend = 16'($urandom);
         req_divisor  = (t % 7 == 0) ? 10'd0 : 10'($urandom);
         res_ready    = (t >= 40) && (t % 2 == 1);
         step();
      end
      chk("toggle occupancy bound", 32'(max_occ > DEPTH), 32'd0);
      chk("toggle ovf_err", 32'(s_ovf), 32'd0);
      drain(200);

      // Randomised traffic
      for (int t = 0; t < 1500; t++) begin
         req_valid    = ($urandom % 4) != 0;
         res_ready    = ($urandom % 3) != 0;
         req_dividend = 16'($urandom);
         req_divisor  = ($urandom % 8 == 0) ? 10'd0 : 10'($urandom);
         step();
      end
      drain(200);
      chk("random ovf_err", 32'(s_ovf), 32'd0);

      // Reset with 10 requests in flight
      res_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         req_valid    = 1'b1;
         req_dividend = 16'(500 + i);
         req_divisor  = 10'(3 + i);
         step();
      end
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      res_ready = 1'b1;
      step();
      chk("mid-reset req_ready", 32'(s_req_ready), 32'd1);
      chk("mid-reset res_valid", 32'(s_res_valid), 32'd0);
      chk("mid-reset res_quotient", 32'(s_q), 32'd0);
      chk("mid-reset res_dbz", 32'(s_dbz), 32'd0);
      chk("mid-reset div_valid_o", 32'(s_div_valid_o), 32'd0);
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
         step();
         if (s_res_valid) ok = 1'b1;
      end
      chk("no stale result after reset", 32'(ok), 32'd0);
      apply_one(tbl[4]);
      drain(50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
